frequency_meter: RTL and testbench

Measures an external digital signal against the master clock: counts its rising edges over a fixed gate window and reports the period between consecutive rising edges in master-clock cycles. This is the receive-side counterpart of the clock-divider generators in the utilities library. It closes loop checks on generated clocks and measures external inputs such as encoders or sensor pulse trains. All logic runs in the master clock domain; the measured signal is treated as asynchronous.

---
 rtl/frequency_meter.sv | 137 +++++++++++++
 tb/tb_frequency_meter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_meter.sv
// Frequency meter: counts SignalIn rising edges per gate window and measures the
// period between consecutive rising edges, all in the InputCLK domain.
module frequency_meter #(
  parameter int MasterFrequency = 100000000,
  parameter int GateFrequency   = 10,
  parameter int bitsNumber      = 24
) (
  input  logic                  InputCLK,
  input  logic                  Reset,
  input  logic                  SignalIn,
  output logic [bitsNumber-1:0] EdgeCount,
  output logic [bitsNumber-1:0] Period,
  output logic                  CountValid,
  output logic                  PeriodValid,
  output logic                  Overflow
);

  localparam int GateLimit = MasterFrequency / GateFrequency;
  localparam logic [bitsNumber-1:0] gateLast = bitsNumber'(GateLimit - 1);
  localparam logic [bitsNumber-1:0] allZeros = {bitsNumber{1'b0}};
  localparam logic [bitsNumber-1:0] allOnes  = {bitsNumber{1'b1}};
  localparam logic [bitsNumber-1:0] countOne = {{(bitsNumber-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } periodState_t;

  logic                  sync1_r;
  logic                  sync2_r;
  logic                  sync3_r;
  logic                  rise_s;
  logic [bitsNumber-1:0] riseExt_s;
  logic                  gateClose_s;
  logic [bitsNumber-1:0] gateCount_r;
  logic [bitsNumber-1:0] edgeAcc_r;

  periodState_t          state_r;
  periodState_t          stateNext_s;
  logic [bitsNumber-1:0] pcount_r;
  logic [bitsNumber-1:0] pcountNext_s;
  logic [bitsNumber-1:0] periodNext_s;
  logic                  periodValidNext_s;
  logic                  overflowNext_s;

  // Two-flop synchronizer plus one delay stage for rising-edge detection
  always_ff @(posedge InputCLK or posedge Reset) begin
    if (Reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= SignalIn;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign rise_s      = sync2_r & ~sync3_r;
  assign riseExt_s   = {{(bitsNumber-1){1'b0}}, rise_s};
  assign gateClose_s = (gateCount_r == gateLast);

  // Gate window counter; a rise on the closing cycle still belongs to the closing window
  always_ff @(posedge InputCLK or posedge Reset) begin
    if (Reset) begin
      gateCount_r <= allZeros;
      edgeAcc_r   <= allZeros;
      EdgeCount   <= allZeros;
      CountValid  <= 1'b0;
    end else if (gateClose_s) begin
      gateCount_r <= allZeros;
      edgeAcc_r   <= allZeros;
      EdgeCount   <= edgeAcc_r + riseExt_s;
      CountValid  <= 1'b1;
    end else begin
      gateCount_r <= gateCount_r + countOne;
      edgeAcc_r   <= edgeAcc_r + riseExt_s;
      CountValid  <= 1'b0;
    end
  end

  // Period FSM state and registered outputs
  always_ff @(posedge InputCLK or posedge Reset) begin
    if (Reset) begin
      state_r     <= IDLE;
      pcount_r    <= allZeros;
      Period      <= allZeros;
      PeriodValid <= 1'b0;
      Overflow    <= 1'b0;
    end else begin
      state_r     <= stateNext_s;
      pcount_r    <= pcountNext_s;
      Period      <= periodNext_s;
      PeriodValid <= periodValidNext_s;
      Overflow    <= overflowNext_s;
    end
  end

  // Period FSM next state: the first edge only arms the measurement
  always_comb begin
    stateNext_s       = state_r;
    pcountNext_s      = pcount_r;
    periodNext_s      = Period;
    periodValidNext_s = 1'b0;
    overflowNext_s    = Overflow;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          stateNext_s    = MEASURE;
          pcountNext_s   = countOne;
          overflowNext_s = 1'b0;
        end else begin
          pcountNext_s   = pcount_r;
        end
      end
      MEASURE: begin
        if (rise_s) begin
          periodNext_s      = pcount_r;
          periodValidNext_s = 1'b1;
          pcountNext_s      = countOne;
          overflowNext_s    = 1'b0;
        end else if (pcount_r == allOnes) begin
          stateNext_s    = IDLE;
          overflowNext_s = 1'b1;
          pcountNext_s   = pcount_r + countOne;
        end else begin
          pcountNext_s   = pcount_r + countOne;
        end
      end
      default: begin
        stateNext_s  = IDLE;
        pcountNext_s = allZeros;
      end
    endcase
  end

endmodule

// File: tb/tb_frequency_meter.sv
// Self-checking bench for frequency_meter: GateLimit=100, 8-bit counters, with a
// reference model built from the list of cycles on which each edge is consumed.
module tb_frequency_meter;

  localparam int GATE = 100;
  localparam int FULL = 255;

  logic       InputCLK = 1'b0;
  logic       Reset    = 1'b1;
  logic       SignalIn = 1'b0;
  logic [7:0] EdgeCount;
  logic [7:0] Period;
  logic       CountValid;
  logic       PeriodValid;
  logic       Overflow;

  int nAssert = 0;
  int nFail   = 0;

  // Reference model state: edges since reset release and consumption edge of each rise
  int edgeNum   = 0;
  int riseQ[$];
  int expCount  = 0;
  int expPeriod = 0;
  bit expCV     = 1'b0;
  bit expPV     = 1'b0;
  bit expOv     = 1'b0;

  frequency_meter #(
    .MasterFrequency(1000),
    .GateFrequency  (10),
    .bitsNumber     (8)
  ) dut (
    .InputCLK   (InputCLK),
    .Reset      (Reset),
    .SignalIn   (SignalIn),
    .EdgeCount  (EdgeCount),
    .Period     (Period),
    .CountValid (CountValid),
    .PeriodValid(PeriodValid),
    .Overflow   (Overflow)
  );

  always #10 InputCLK = ~InputCLK;

  // Expected outputs after each clock edge, from window membership and rise spacing
  always @(posedge InputCLK) begin : refModel
    int e, cnt, last, prev;
    if (Reset) begin
      edgeNum   <= 0;
      expCount  <= 0;
      expPeriod <= 0;
      expCV     <= 1'b0;
      expPV     <= 1'b0;
      expOv     <= 1'b0;
    end else begin
      e = edgeNum + 1;
      edgeNum <= e;
      expCV <= ((e % GATE) == 0);
      if ((e % GATE) == 0) begin
        cnt = 0;
        foreach (riseQ[i]) if (riseQ[i] > e - GATE && riseQ[i] <= e) cnt++;
        expCount <= cnt;
      end
      last = -1;
      prev = -1;
      foreach (riseQ[i]) if (riseQ[i] <= e) begin prev = last; last = riseQ[i]; end
      expPV <= (last == e && prev >= 0 && (e - prev) <= FULL);
      if (last == e && prev >= 0 && (e - prev) <= FULL) expPeriod <= e - prev;
      expOv <= (last >= 0 && (e - last) >= FULL);
    end
  end

  // Drive SignalIn at a falling clock edge; a low-to-high step is consumed three edges later
  task automatic tick(input logic v);
    @(negedge InputCLK);
    if (v && !SignalIn && !Reset) riseQ.push_back(edgeNum + 3);
    SignalIn = v;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge InputCLK);
    nAssert += 5;
    if (EdgeCount !== 8'd0)  begin nFail++; $display("FAIL reset_edgecount got %0d want 0", EdgeCount); end
    if (Period !== 8'd0)     begin nFail++; $display("FAIL reset_period got %0d want 0", Period); end
    if (CountValid !== 1'b0) begin nFail++; $display("FAIL reset_countvalid got %b want 0", CountValid); end
    if (PeriodValid !== 1'b0) begin nFail++; $display("FAIL reset_periodvalid got %b want 0", PeriodValid); end
    if (Overflow !== 1'b0)   begin nFail++; $display("FAIL reset_overflow got %b want 0", Overflow); end
    Reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0);
      nAssert += 2;
      if (CountValid !== 1'b0) begin nFail++; $display("FAIL post_reset_cv @%0d got %b want 0", edgeNum, CountValid); end
      if (EdgeCount !== 8'(expCount)) begin nFail++; $display("FAIL post_reset_count @%0d got %0d want %0d", edgeNum, EdgeCount, expCount); end
    end
  endtask

  task automatic test_square(input int p, input int n);
    int lo, hi, firstRise;
    logic v;
    lo = GATE / p;
    hi = (GATE + p - 1) / p;
    firstRise = -1;
    for (int i = 0; i < n; i++) begin
      v = ((i % p) >= (p - p / 2));
      if (firstRise < 0 && (i % p) == (p - p / 2)) firstRise = edgeNum + 4;
      tick(v);
      nAssert += 6;
      if (CountValid !== expCV)       begin nFail++; $display("FAIL sq%0d_cv @%0d got %b want %b", p, edgeNum, CountValid, expCV); end
      if (PeriodValid !== expPV)      begin nFail++; $display("FAIL sq%0d_pv @%0d got %b want %b", p, edgeNum, PeriodValid, expPV); end
      if (EdgeCount !== 8'(expCount)) begin nFail++; $display("FAIL sq%0d_count @%0d got %0d want %0d", p, edgeNum, EdgeCount, expCount); end
      if (Period !== 8'(expPeriod))   begin nFail++; $display("FAIL sq%0d_period @%0d got %0d want %0d", p, edgeNum, Period, expPeriod); end
      if (Overflow !== expOv)         begin nFail++; $display("FAIL sq%0d_ovf_model @%0d got %b want %b", p, edgeNum, Overflow, expOv); end
      if (Overflow !== 1'b0)          begin nFail++; $display("FAIL sq%0d_ovf @%0d got %b want 0", p, edgeNum, Overflow); end
      if (PeriodValid && firstRise >= 0 && edgeNum > firstRise) begin
        nAssert++;
        if (Period !== 8'(p)) begin nFail++; $display("FAIL sq%0d_period_value @%0d got %0d want %0d", p, edgeNum, Period, p); end
      end
      if (CountValid && firstRise >= 0 && edgeNum - GATE >= firstRise) begin
        nAssert++;
        if (int'(EdgeCount) < lo || int'(EdgeCount) > hi) begin
          nFail++; $display("FAIL sq%0d_window @%0d got %0d want %0d..%0d", p, edgeNum, EdgeCount, lo, hi);
        end
      end
    end
  endtask

  task automatic test_overflow();
    int r1, r2, r3;
    logic v;
    r1 = -1; r2 = -1; r3 = -1;
    for (int i = 0; i < 700; i++) begin
      v = (i >= 10 && i < 15) || (i >= 600 && i < 610) || (i >= 620 && i < 630);
      tick(v);
      if (i == 10)  r1 = riseQ[riseQ.size() - 1];
      if (i == 600) r2 = riseQ[riseQ.size() - 1];
      if (i == 620) r3 = riseQ[riseQ.size() - 1];
      nAssert += 5;
      if (CountValid !== expCV)       begin nFail++; $display("FAIL ovf_cv @%0d got %b want %b", edgeNum, CountValid, expCV); end
      if (PeriodValid !== expPV)      begin nFail++; $display("FAIL ovf_pv @%0d got %b want %b", edgeNum, PeriodValid, expPV); end
      if (EdgeCount !== 8'(expCount)) begin nFail++; $display("FAIL ovf_count @%0d got %0d want %0d", edgeNum, EdgeCount, expCount); end
      if (Period !== 8'(expPeriod))   begin nFail++; $display("FAIL ovf_period @%0d got %0d want %0d", edgeNum, Period, expPeriod); end
      if (Overflow !== expOv)         begin nFail++; $display("FAIL ovf_flag_model @%0d got %b want %b", edgeNum, Overflow, expOv); end
      if (r1 >= 0 && (edgeNum == r1 + FULL - 1 || edgeNum == r1 + FULL)) begin
        nAssert++;
        if (Overflow !== (edgeNum == r1 + FULL)) begin
          nFail++; $display("FAIL ovf_timing @%0d got %b want %b", edgeNum, Overflow, (edgeNum == r1 + FULL));
        end
      end
      if (CountValid && r1 >= 0 && edgeNum >= r1 + GATE && r2 < 0) begin
        nAssert++;
        if (EdgeCount !== 8'd0) begin nFail++; $display("FAIL ovf_idle_window @%0d got %0d want 0", edgeNum, EdgeCount); end
      end
      if (r2 >= 0 && edgeNum == r2) begin
        nAssert += 2;
        if (PeriodValid !== 1'b0) begin nFail++; $display("FAIL ovf_rearm_pv @%0d got %b want 0", edgeNum, PeriodValid); end
        if (Overflow !== 1'b0)    begin nFail++; $display("FAIL ovf_clear @%0d got %b want 0", edgeNum, Overflow); end
      end
      if (r3 >= 0 && edgeNum == r3) begin
        nAssert += 2;
        if (PeriodValid !== 1'b1) begin nFail++; $display("FAIL ovf_second_pv @%0d got %b want 1", edgeNum, PeriodValid); end
        if (Period !== 8'd20)     begin nFail++; $display("FAIL ovf_second_period @%0d got %0d want 20", edgeNum, Period); end
      end
    end
  endtask

  task automatic test_gate_edge();
    int tgt, guard;
    logic v;
    tgt = ((edgeNum + 350) / GATE) * GATE - 3;
    guard = 0;
    while (edgeNum <= tgt + 110 && guard < 1000) begin
      guard++;
      v = ((edgeNum + 1) >= tgt && (edgeNum + 1) < tgt + 5);
      tick(v);
      nAssert += 2;
      if (CountValid !== expCV)       begin nFail++; $display("FAIL gate_cv @%0d got %b want %b", edgeNum, CountValid, expCV); end
      if (EdgeCount !== 8'(expCount)) begin nFail++; $display("FAIL gate_count @%0d got %0d want %0d", edgeNum, EdgeCount, expCount); end
      if (CountValid && (edgeNum == tgt - 97 || edgeNum == tgt + 3 || edgeNum == tgt + 103)) begin
        nAssert++;
        if (EdgeCount !== ((edgeNum == tgt + 3) ? 8'd1 : 8'd0)) begin
          nFail++; $display("FAIL gate_closing_rise @%0d got %0d want %0d", edgeNum, EdgeCount, (edgeNum == tgt + 3));
        end
      end
    end
    nAssert++;
    if (guard >= 1000) begin nFail++; $display("FAIL gate_budget got %0d cycles want <1000", guard); end
  endtask

  task automatic test_async();
    int start, off;
    start = edgeNum;
    off = $urandom_range(1, 4) + 5 * $urandom_range(0, 3);
    fork
      begin
        #(off);
        repeat (96) begin
          #125;
          if (!SignalIn && !Reset) riseQ.push_back(edgeNum + 3);
          SignalIn = ~SignalIn;
        end
        SignalIn = 1'b0;
      end
      begin
        for (int i = 0; i < 620; i++) begin
          @(negedge InputCLK);
          nAssert += 5;
          if (CountValid !== expCV)       begin nFail++; $display("FAIL async_cv @%0d got %b want %b", edgeNum, CountValid, expCV); end
          if (PeriodValid !== expPV)      begin nFail++; $display("FAIL async_pv @%0d got %b want %b", edgeNum, PeriodValid, expPV); end
          if (EdgeCount !== 8'(expCount)) begin nFail++; $display("FAIL async_count @%0d got %0d want %0d", edgeNum, EdgeCount, expCount); end
          if (Period !== 8'(expPeriod))   begin nFail++; $display("FAIL async_period @%0d got %0d want %0d", edgeNum, Period, expPeriod); end
          if (Overflow !== expOv)         begin nFail++; $display("FAIL async_ovf @%0d got %b want %b", edgeNum, Overflow, expOv); end
          if (PeriodValid && edgeNum > start + 15 && edgeNum < start + 600) begin
            nAssert++;
            if (Period !== 8'd12 && Period !== 8'd13) begin nFail++; $display("FAIL async_period_range @%0d got %0d want 12..13", edgeNum, Period); end
          end
          if (CountValid && edgeNum - GATE >= start + 15 && edgeNum < start + 600) begin
            nAssert++;
            if (EdgeCount !== 8'd7 && EdgeCount !== 8'd8) begin nFail++; $display("FAIL async_count_range @%0d got %0d want 7..8", edgeNum, EdgeCount); end
          end
        end
      end
    join
  endtask

  task automatic test_random();
    int len, done;
    logic v;
    v = 1'b0;
    done = 0;
    while (done < 700) begin
      if (v) len = $urandom_range(1, 15);
      else   len = ($urandom_range(0, 19) == 0) ? 270 : $urandom_range(1, 30);
      for (int j = 0; j < len; j++) begin
        tick(v);
        nAssert += 5;
        if (CountValid !== expCV)       begin nFail++; $display("FAIL rnd_cv @%0d got %b want %b", edgeNum, CountValid, expCV); end
        if (PeriodValid !== expPV)      begin nFail++; $display("FAIL rnd_pv @%0d got %b want %b", edgeNum, PeriodValid, expPV); end
        if (EdgeCount !== 8'(expCount)) begin nFail++; $display("FAIL rnd_count @%0d got %0d want %0d", edgeNum, EdgeCount, expCount); end
        if (Period !== 8'(expPeriod))   begin nFail++; $display("FAIL rnd_period @%0d got %0d want %0d", edgeNum, Period, expPeriod); end
        if (Overflow !== expOv)         begin nFail++; $display("FAIL rnd_ovf @%0d got %b want %b", edgeNum, Overflow, expOv); end
      end
      done += len;
      v = ~v;
    end
  endtask

  task automatic test_reset_mid();
    int pvSeen;
    for (int i = 0; i < 45; i++) tick((i % 10) >= 5);
    #6;
    Reset = 1'b1;
    SignalIn = 1'b0;
    riseQ.delete();
    #1;
    nAssert += 5;
    if (EdgeCount !== 8'd0)   begin nFail++; $display("FAIL midrst_edgecount got %0d want 0", EdgeCount); end
    if (Period !== 8'd0)      begin nFail++; $display("FAIL midrst_period got %0d want 0", Period); end
    if (CountValid !== 1'b0)  begin nFail++; $display("FAIL midrst_countvalid got %b want 0", CountValid); end
    if (PeriodValid !== 1'b0) begin nFail++; $display("FAIL midrst_periodvalid got %b want 0", PeriodValid); end
    if (Overflow !== 1'b0)    begin nFail++; $display("FAIL midrst_overflow got %b want 0", Overflow); end
    repeat (2) @(negedge InputCLK);
    Reset = 1'b0;
    pvSeen = 0;
    for (int i = 0; i < 250; i++) begin
      tick((i % 10) >= 5);
      nAssert += 5;
      if (CountValid !== expCV)       begin nFail++; $display("FAIL midrst_cv @%0d got %b want %b", edgeNum, CountValid, expCV); end
      if (PeriodValid !== expPV)      begin nFail++; $display("FAIL midrst_pv @%0d got %b want %b", edgeNum, PeriodValid, expPV); end
      if (EdgeCount !== 8'(expCount)) begin nFail++; $display("FAIL midrst_count @%0d got %0d want %0d", edgeNum, EdgeCount, expCount); end
      if (Period !== 8'(expPeriod))   begin nFail++; $display("FAIL midrst_per @%0d got %0d want %0d", edgeNum, Period, expPeriod); end
      if (Overflow !== expOv)         begin nFail++; $display("FAIL midrst_ovf @%0d got %b want %b", edgeNum, Overflow, expOv); end
      if (edgeNum == GATE - 1 || edgeNum == GATE) begin
        nAssert++;
        if (CountValid !== (edgeNum == GATE)) begin nFail++; $display("FAIL midrst_first_cv @%0d got %b want %b", edgeNum, CountValid, (edgeNum == GATE)); end
      end
      if (PeriodValid && pvSeen == 0) begin
        pvSeen = 1;
        nAssert += 2;
        if (Period !== 8'd10)    begin nFail++; $display("FAIL midrst_first_period got %0d want 10", Period); end
        if (riseQ.size() !== 2)  begin nFail++; $display("FAIL midrst_first_pv_edge got edge %0d want edge 2", riseQ.size()); end
      end
    end
    nAssert++;
    if (pvSeen !== 1) begin nFail++; $display("FAIL midrst_pv_seen got %0d want 1", pvSeen); end
  endtask

  initial begin
    test_reset();
    test_square(10, 400);
    test_square(7, 400);
    test_overflow();
    test_gate_edge();
    test_async();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
